hysteresis_shaper: RTL and testbench

Clocked, parametrised hysteresis comparator that converts a sampled digital waveform into a debounced square wave. It has runtime thresholds, a dwell filter, edge pulses and period measurement. It sits after the waveform generator/ADC sample path and feeds the square-wave output and frequency-display logic. The hysteresis decision is registered, so there are no inferred latches.

---
 rtl/hyst_pkg.sv | 20 ++
 rtl/edge_period_meter.sv | 45 ++++
 rtl/hysteresis_shaper.sv | 143 ++++++++++++++
 tb/tb_hysteresis_shaper.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyst_pkg.sv
// Shared state encoding and default widths for the hysteresis shaper and its period meter.
package hyst_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DWELL_W_DEF = 4;
    localparam int PER_W_DEF   = 16;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } hyst_state_t;

    // HIGH and ARM_LO both sit on the high output level.
    function automatic logic level_of(input hyst_state_t s);
        return (s == HIGH) || (s == ARM_LO);
    endfunction

endpackage

// File: rtl/edge_period_meter.sv
// Measures clk cycles between successive rise events with a saturating counter.
// The first rise after reset only arms the counter.
module edge_period_meter
    import hyst_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             rise,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

    logic [PER_W-1:0] cnt_p0;
    logic             armed_p0;

    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            cnt_p0       <= '0;
            armed_p0     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= rise && armed_p0;
            if (rise) begin
                if (armed_p0) begin
                    period <= cnt_p0;
                end
                cnt_p0   <= CNT_ONE;
                armed_p0 <= 1'b1;
            end else begin
                cnt_p0 <= sat_inc(cnt_p0);
            end
        end
    end

endmodule

// File: rtl/hysteresis_shaper.sv
// Hysteresis comparator with dwell filter: turns sampled data into a debounced
// square wave with edge pulses and rise-to-rise period measurement.
module hysteresis_shaper
    import hyst_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int PER_W   = PER_W_DEF
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  wave,
    input  logic [DATA_W-1:0]  thr_hi,
    input  logic [DATA_W-1:0]  thr_lo,
    input  logic [DWELL_W-1:0] dwell,
    output logic               square_wave,
    output logic               rise,
    output logic               fall,
    output logic [PER_W-1:0]   period,
    output logic               period_valid,
    output logic               cfg_err
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    hyst_state_t        state_p0;
    logic [DWELL_W-1:0] cnt_p0;

    hyst_state_t        state_nx;
    logic [DWELL_W-1:0] cnt_nx;
    logic               rise_nx;
    logic               fall_nx;

    logic               above;
    logic               below;
    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W:0]   cnt_inc;
    logic               arm_done;

    assign above     = wave > thr_hi;
    assign below     = wave < thr_lo;
    assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
    assign cnt_inc   = {1'b0, cnt_p0} + (DWELL_W + 1)'(1);
    assign arm_done  = cnt_inc >= {1'b0, dwell_eff};

    // Registered cfg_err gates evaluation, so bad thresholds bite one cycle late.
    always_comb begin
        state_nx = state_p0;
        cnt_nx   = cnt_p0;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        if (cfg_err) begin
            cnt_nx = '0;
            if (state_p0 == ARM_HI) state_nx = LOW;
            if (state_p0 == ARM_LO) state_nx = HIGH;
        end else if (in_valid) begin
            case (state_p0)
                LOW: begin
                    if (above) begin
                        if (dwell_eff == DWELL_ONE) begin
                            state_nx = HIGH;
                            rise_nx  = 1'b1;
                        end else begin
                            state_nx = ARM_HI;
                            cnt_nx   = DWELL_ONE;
                        end
                    end
                end
                ARM_HI: begin
                    if (!above) begin
                        state_nx = LOW;
                        cnt_nx   = '0;
                    end else if (arm_done) begin
                        state_nx = HIGH;
                        cnt_nx   = '0;
                        rise_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc[DWELL_W-1:0];
                    end
                end
                HIGH: begin
                    if (below) begin
                        if (dwell_eff == DWELL_ONE) begin
                            state_nx = LOW;
                            fall_nx  = 1'b1;
                        end else begin
                            state_nx = ARM_LO;
                            cnt_nx   = DWELL_ONE;
                        end
                    end
                end
                ARM_LO: begin
                    if (!below) begin
                        state_nx = HIGH;
                        cnt_nx   = '0;
                    end else if (arm_done) begin
                        state_nx = LOW;
                        cnt_nx   = '0;
                        fall_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc[DWELL_W-1:0];
                    end
                end
                default: begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Stage p0: FSM state and all level/edge outputs registered together.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_p0    <= LOW;
            cnt_p0      <= '0;
            square_wave <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_p0    <= state_nx;
            cnt_p0      <= cnt_nx;
            square_wave <= level_of(state_nx);
            rise        <= rise_nx;
            fall        <= fall_nx;
            cfg_err     <= thr_lo > thr_hi;
        end
    end

    // The meter sees the rise decision so period_valid lines up with rise.
    edge_period_meter #(
        .PER_W(PER_W)
    ) u_meter (
        .clk          (clk),
        .rst_         (rst_),
        .rise         (rise_nx),
        .period       (period),
        .period_valid (period_valid)
    );

endmodule

// File: tb/tb_hysteresis_shaper.sv
// Scoreboard bench for hysteresis_shaper: directed scenarios plus randomized
// traffic against a level/streak reference model; a PER_W=4 copy checks saturation.
module tb_hysteresis_shaper;

    logic        clk;
    logic        rst_;
    logic        in_valid;
    logic [7:0]  wave;
    logic [7:0]  thr_hi;
    logic [7:0]  thr_lo;
    logic [3:0]  dwell;

    logic        sq_o, rise_o, fall_o, pv_o, cfg_o;
    logic [15:0] per_o;
    logic        sq4_o, rise4_o, fall4_o, pv4_o, cfg4_o;
    logic [3:0]  per4_o;

    typedef struct packed {
        logic        sq;
        logic        rs;
        logic        fl;
        logic        pv;
        logic        cfg;
        logic [15:0] per;
        logic [3:0]  per4;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_cyc  = 0;

    // Reference model: current output level, run of qualifying samples toward the
    // other level, registered config-error flag, and time since the last rise.
    bit   m_level;
    int   m_streak;
    bit   m_cfg;
    bit   m_armed;
    int   m_t;
    int   m_per16;
    int   m_per4;

    hysteresis_shaper #(.DATA_W(8), .DWELL_W(4), .PER_W(16)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .wave(wave),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .dwell(dwell),
        .square_wave(sq_o), .rise(rise_o), .fall(fall_o),
        .period(per_o), .period_valid(pv_o), .cfg_err(cfg_o)
    );

    hysteresis_shaper #(.DATA_W(8), .DWELL_W(4), .PER_W(4)) dut4 (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .wave(wave),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .dwell(dwell),
        .square_wave(sq4_o), .rise(rise4_o), .fall(fall4_o),
        .period(per4_o), .period_valid(pv4_o), .cfg_err(cfg4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, n_cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_level  = 1'b0;
        m_streak = 0;
        m_cfg    = 1'b0;
        m_armed  = 1'b0;
        m_t      = 0;
        m_per16  = 0;
        m_per4   = 0;
    endtask

    task automatic push_exp(input bit r, input bit f, input bit pv);
        exp_t e;
        e.sq   = m_level;
        e.rs   = r;
        e.fl   = f;
        e.pv   = pv;
        e.cfg  = m_cfg;
        e.per  = 16'(m_per16);
        e.per4 = 4'(m_per4);
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit v, input int w, input int hi, input int lo, input int dw);
        bit r = 0, f = 0, pv = 0, q;
        int deff;
        if (m_cfg) begin
            m_streak = 0;
        end else if (v) begin
            deff = (dw == 0) ? 1 : dw;
            q = m_level ? (w < lo) : (w > hi);
            if (q) begin
                m_streak++;
                if (m_streak >= deff) begin
                    m_level  = !m_level;
                    m_streak = 0;
                    if (m_level) r = 1; else f = 1;
                end
            end else begin
                m_streak = 0;
            end
        end
        m_cfg = (lo > hi);
        if (r) begin
            if (m_armed) begin
                pv      = 1;
                m_per16 = imin(m_t, 65535);
                m_per4  = imin(m_t, 15);
            end
            m_t     = 1;
            m_armed = 1;
        end else if (m_t < 1000000) begin
            m_t++;
        end
        push_exp(r, f, pv);
    endtask

    task automatic drive(input bit v, input int w, input int hi, input int lo, input int dw);
        @(negedge clk);
        rst_     = 1'b0;
        in_valid = v;
        wave     = 8'(w);
        thr_hi   = 8'(hi);
        thr_lo   = 8'(lo);
        dwell    = 4'(dw);
        model_step(v, w, hi, lo, dw);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_sq"},   sq_o,   0);
        chk({tag, "_rise"}, rise_o, 0);
        chk({tag, "_fall"}, fall_o, 0);
        chk({tag, "_per"},  per_o,  0);
        chk({tag, "_pv"},   pv_o,   0);
        chk({tag, "_cfg"},  cfg_o,  0);
        chk({tag, "_per4"}, per4_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_     = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        push_exp(0, 0, 0);
    endtask

    // Monitor: every output sample after an edge is matched to the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("square_wave",   sq_o,   e.sq);
                chk("rise",          rise_o, e.rs);
                chk("fall",          fall_o, e.fl);
                chk("period_valid",  pv_o,   e.pv);
                chk("cfg_err",       cfg_o,  e.cfg);
                chk("period",        per_o,  e.per);
                chk("period4",       per4_o, e.per4);
                chk("period_valid4", pv4_o,  e.pv);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi, lo, dw, w;
        bit phase;
        rst_     = 1'b1;
        in_valid = 1'b0;
        wave     = '0;
        thr_hi   = '0;
        thr_lo   = '0;
        dwell    = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_zero_outputs("reset");

        // Basic hysteresis, dwell 1
        drive(1, 100, 192, 64, 1);
        drive(1, 200, 192, 64, 1);
        drive(1, 150, 192, 64, 1);
        drive(1, 100, 192, 64, 1);
        drive(1, 60,  192, 64, 1);
        drive(1, 100, 192, 64, 1);

        // Dwell filter, dwell 3
        drive(1, 200, 192, 64, 3);
        drive(1, 200, 192, 64, 3);
        drive(1, 100, 192, 64, 3);
        drive(1, 200, 192, 64, 3);
        drive(1, 200, 192, 64, 3);
        drive(1, 200, 192, 64, 3);

        // Back to low, then valid gaps with dwell 2
        drive(1, 10, 192, 64, 1);
        drive(1, 200, 192, 64, 2);
        for (int i = 0; i < 5; i++) drive(0, 0, 192, 64, 2);
        drive(1, 200, 192, 64, 2);

        // Square input with rises 40 clk apart
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) drive(1, 0, 192, 64, 1);
            for (int i = 0; i < 20; i++) drive(1, 220, 192, 64, 1);
        end

        // Config error while arming high
        drive(1, 0, 192, 64, 1);
        drive(1, 200, 192, 64, 3);
        for (int i = 0; i < 6; i++) drive(1, 255, 100, 200, 3);
        for (int i = 0; i < 4; i++) drive(1, 200, 192, 64, 3);

        // Reset while high with the period counter armed, then re-arm only
        drive(1, 0, 192, 64, 1);
        drive(1, 200, 192, 64, 1);
        drive(1, 0, 192, 64, 1);
        drive(1, 200, 192, 64, 1);
        drive(1, 200, 192, 64, 1);
        do_reset();
        do_reset();
        drive(1, 200, 192, 64, 1);
        drive(1, 0, 192, 64, 1);
        for (int i = 0; i < 10; i++) drive(1, 200, 192, 64, 1);
        drive(1, 0, 192, 64, 1);
        drive(1, 200, 192, 64, 1);

        // Randomized traffic
        hi = 192; lo = 64; dw = 1; phase = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if ((n % 60) == 0) begin
                    hi = $urandom_range(100, 240);
                    lo = $urandom_range(0, hi);
                    if ($urandom_range(0, 9) == 0) lo = $urandom_range(hi, 255);
                    dw = $urandom_range(0, 5);
                end
                if ((n % 23) == 11 && $urandom_range(0, 1) == 1) dw = $urandom_range(0, 5);
                if ($urandom_range(0, 9) == 0) phase = !phase;
                if ($urandom_range(0, 7) == 0) w = $urandom_range(0, 255);
                else if (phase) w = $urandom_range(hi, 255);
                else w = $urandom_range(0, lo);
                drive($urandom_range(0, 3) != 0, w, hi, lo, dw);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
